// File: rtl/imm_encoder_if.sv
// rtl/imm_encoder_if.sv - request/result handshake bundle for imm_encoder
interface imm_encoder_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_imm;
  logic [2:0]       in_imm_src;
  logic [31:0]      in_base;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_imm, in_imm_src, in_base, out_ready,
    input  in_ready, out_valid, out_instr, out_err, err_count
  );

  modport slave (
    input  in_valid, in_imm, in_imm_src, in_base, out_ready,
    output in_ready, out_valid, out_instr, out_err, err_count
  );
endinterface

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - packs a 32-bit immediate into RV32 I/S/B/U/J/CSR fields of a template
// Optional IMM_RANGE_CHECK_EN flags immediates that do not fit the selected format.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  imm_encoder_if.slave  bus
);

  logic             s1_valid;
  logic [31:0]      s1_imm;
  logic [31:0]      s1_base;
  logic [2:0]       s1_src;
  logic             s2_valid;
  logic [31:0]      s2_instr;
  logic             s2_err;
  logic [CNT_W-1:0] cnt;

  logic             s2_adv;
  logic             s1_adv;
  logic             in_fire;
  logic [31:0]      enc_instr;
  logic             illegal;
  logic             enc_err;

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = s1_valid && s2_adv;
  assign bus.in_ready = !s1_valid || s2_adv;
  assign in_fire      = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_imm   <= '0;
      s1_base  <= '0;
      s1_src   <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_imm   <= bus.in_imm;
      s1_base  <= bus.in_base;
      s1_src   <= bus.in_imm_src;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Only the immediate-field bits are overwritten; everything else is the template.
  always_comb begin
    enc_instr = s1_base;
    illegal   = 1'b0;
    case (s1_src)
      3'b000: enc_instr[31:20] = s1_imm[11:0];
      3'b001: begin
        enc_instr[31:25] = s1_imm[11:5];
        enc_instr[11:7]  = s1_imm[4:0];
      end
      3'b010: begin
        enc_instr[31]    = s1_imm[12];
        enc_instr[30:25] = s1_imm[10:5];
        enc_instr[11:8]  = s1_imm[4:1];
        enc_instr[7]     = s1_imm[11];
      end
      3'b011: enc_instr[31:12] = s1_imm[31:12];
      3'b100: begin
        enc_instr[31]    = s1_imm[20];
        enc_instr[30:21] = s1_imm[10:1];
        enc_instr[20]    = s1_imm[11];
        enc_instr[19:12] = s1_imm[19:12];
      end
      3'b101: enc_instr[19:15] = s1_imm[4:0];
      default: illegal = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic range_err;

  // A sign-extended field fits when all bits above it agree with its sign bit.
  always_comb begin
    range_err = 1'b0;
    case (s1_src)
      3'b000, 3'b001: range_err = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
      3'b010: range_err = !((&s1_imm[31:12]) || !(|s1_imm[31:12])) || s1_imm[0];
      3'b011: range_err = |s1_imm[11:0];
      3'b100: range_err = !((&s1_imm[31:20]) || !(|s1_imm[31:20])) || s1_imm[0];
      3'b101: range_err = |s1_imm[31:5];
      default: range_err = 1'b0;
    endcase
  end

  assign enc_err = illegal || range_err;
`else
  assign enc_err = illegal;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_instr <= '0;
      s2_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_instr <= enc_instr;
        s2_err   <= enc_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (s2_valid && bus.out_ready && s2_err && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_instr = s2_instr;
  assign bus.out_err   = s2_err;
  assign bus.err_count = cnt;

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - randomized self-checking bench for imm_encoder with a field-level model
module tb_imm_encoder;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_encoder_if #(.CNT_W(CW)) ifc ();
  imm_encoder #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [31:0] imm;
    logic [2:0]  src;
    logic        enc;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          occ = 0;
  int          cnt_model = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] held_instr = '0;
  logic        held_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sx(input int n, input logic [31:0] v);
    logic signed [31:0] t;
    t = $signed(v << (32 - n));
    return t >>> (32 - n);
  endfunction

  function automatic logic encodable(input logic [31:0] imm, input logic [2:0] src);
    int s;
    s = $signed(imm);
    case (src)
      3'd0, 3'd1: return s >= -2048 && s <= 2047;
      3'd2:       return s >= -4096 && s <= 4094 && (s % 2 == 0);
      3'd3:       return (imm % 4096) == 0;
      3'd4:       return s >= -1048576 && s <= 1048574 && (s % 2 == 0);
      3'd5:       return imm < 32;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] base, input logic [31:0] imm, input logic [2:0] src);
    logic [31:0] mask, field;
    exp_t e;
    case (src)
      3'd0: begin mask = 32'hFFF00000; field = imm << 20; end
      3'd1: begin mask = 32'hFE000F80; field = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7); end
      3'd2: begin
        mask  = 32'hFE000F80;
        field = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25)
              | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
      end
      3'd3: begin mask = 32'hFFFFF000; field = imm; end
      3'd4: begin
        mask  = 32'hFFFFF000;
        field = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
              | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12);
      end
      3'd5: begin mask = 32'h000F8000; field = (imm & 32'h1F) << 15; end
      default: begin mask = 32'h0; field = 32'h0; end
    endcase
    e.instr = (base & ~mask) | (field & mask);
    e.enc   = encodable(imm, src);
`ifdef IMM_RANGE_CHECK_EN
    e.err   = (src > 3'd5) || !e.enc;
`else
    e.err   = (src > 3'd5);
`endif
    e.imm   = imm;
    e.src   = src;
    return e;
  endfunction

  // Reference decoder: recovers the immediate the core would see from an encoded word.
  function automatic logic [31:0] decode(input logic [31:0] i, input logic [2:0] src);
    case (src)
      3'd0: return sx(12, {20'b0, i[31:20]});
      3'd1: return sx(12, {20'b0, i[31:25], i[11:7]});
      3'd2: return sx(13, {19'b0, i[31], i[7], i[30:25], i[11:8], 1'b0});
      3'd3: return {i[31:12], 12'b0};
      3'd4: return sx(21, {11'b0, i[31], i[19:12], i[20], i[30:21], 1'b0});
      3'd5: return {27'b0, i[19:15]};
      default: return 32'h0;
    endcase
  endfunction

  // Compare process: tracks every handshake and checks outputs against the model each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        occ = 0;
        cnt_model = 0;
        stall_prev = 1'b0;
      end else begin
        check("in_ready", {31'b0, ifc.in_ready}, {31'b0, (occ < 2) || ifc.out_ready});
        check("err_count", {{(32-CW){1'b0}}, ifc.err_count}, cnt_model);
        if (stall_prev) begin
          check("stall_valid", {31'b0, ifc.out_valid}, 32'd1);
          check("stall_instr", ifc.out_instr, held_instr);
          check("stall_err", {31'b0, ifc.out_err}, {31'b0, held_err});
        end
        if (ifc.out_valid && ifc.out_ready) begin
          check("result_expected", {31'b0, q.size() != 0}, 32'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("out_instr", ifc.out_instr, e.instr);
            check("out_err", {31'b0, ifc.out_err}, {31'b0, e.err});
            if (e.enc && e.src <= 3'd5)
              check("roundtrip", decode(ifc.out_instr, e.src), e.imm);
            if (e.err && cnt_model < (1 << CW) - 1) cnt_model++;
            occ--;
          end
        end
        stall_prev = ifc.out_valid && !ifc.out_ready;
        held_instr = ifc.out_instr;
        held_err   = ifc.out_err;
        if (ifc.in_valid && ifc.in_ready) begin
          q.push_back(model(ifc.in_base, ifc.in_imm, ifc.in_imm_src));
          occ++;
        end
      end
    end
  end

  task automatic drive(input logic [31:0] base, input logic [31:0] imm, input logic [2:0] src);
    ifc.in_base    = base;
    ifc.in_imm     = imm;
    ifc.in_imm_src = src;
    ifc.in_valid   = 1'b1;
  endtask

  // Holds a request until accepted; expects to be entered at posedge+1 and returns at posedge+1.
  task automatic send(input logic [31:0] base, input logic [31:0] imm, input logic [2:0] src);
    bit done = 0;
    drive(base, imm, src);
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      done = ifc.in_ready;
      @(posedge clk); #1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    ifc.in_valid = 1'b0;
  endtask

  task automatic single(input string name, input logic [31:0] base, input logic [31:0] imm,
                        input logic [2:0] src, input logic [31:0] exp_instr, input logic exp_err);
    @(posedge clk); #1;
    drive(base, imm, src);
    @(negedge clk);
    check({name, "_in_ready"}, {31'b0, ifc.in_ready}, 32'd1);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    check({name, "_lat1"}, {31'b0, ifc.out_valid}, 32'd0);
    @(negedge clk);
    check({name, "_lat2"}, {31'b0, ifc.out_valid}, 32'd1);
    check({name, "_instr"}, ifc.out_instr, exp_instr);
    check({name, "_err"}, {31'b0, ifc.out_err}, {31'b0, exp_err});
    @(negedge clk);
  endtask

  task automatic rand_req();
    int r;
    logic [2:0] src;
    logic [31:0] imm;
    r = $urandom_range(0, 15);
    src = (r < 14) ? 3'(r % 6) : 3'(r - 8);
    case (src)
      3'd0, 3'd1: imm = sx(12, $urandom);
      3'd2:       imm = sx(13, $urandom) & ~32'h1;
      3'd3:       imm = $urandom & 32'hFFFFF000;
      3'd4:       imm = sx(21, $urandom) & ~32'h1;
      default:    imm = 32'($urandom_range(0, 31));
    endcase
    if ($urandom_range(0, 4) == 0) imm = $urandom;
    drive($urandom, imm, src);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hs;
    logic [31:0] held;
    int err_exp;
    ifc.in_valid = 1'b0; ifc.in_imm = '0; ifc.in_imm_src = '0; ifc.in_base = '0;
    ifc.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'b0, ifc.out_valid}, 32'd0);
    check("rst_out_instr", ifc.out_instr, 32'd0);
    check("rst_out_err", {31'b0, ifc.out_err}, 32'd0);
    check("rst_err_count", {{(32-CW){1'b0}}, ifc.err_count}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    single("i_neg1", 32'h00000013, 32'hFFFFFFFF, 3'b000, 32'hFFF00013, 1'b0);
    single("b_neg2", 32'h00000063, 32'hFFFFFFFE, 3'b010, 32'hFE000FE3, 1'b0);
    single("j_800", 32'h0000006F, 32'h00000800, 3'b100, 32'h0010006F, 1'b0);
`ifdef IMM_RANGE_CHECK_EN
    err_exp = 1;
`else
    err_exp = 0;
`endif
    single("i_800", 32'h00000013, 32'h00000800, 3'b000, 32'h80000013, err_exp[0]);
    check("i_800_count", {{(32-CW){1'b0}}, ifc.err_count}, err_exp);
    single("src111", 32'h00000013, 32'h12345678, 3'b111, 32'h00000013, 1'b1);
    check("src111_count", {{(32-CW){1'b0}}, ifc.err_count}, err_exp + 1);

    // Backpressure: two requests fill the pipe, the third must wait.
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    send(32'h00000013, 32'h00000005, 3'b000);
    send(32'h00000023, 32'h00000011, 3'b001);
    drive(32'h00000037, 32'hABCDE000, 3'b011);
    held = model(32'h00000013, 32'h00000005, 3'b000).instr;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_in_ready", {31'b0, ifc.in_ready}, 32'd0);
      check("bp_hold", ifc.out_instr, held);
    end
    @(posedge clk); #1;
    ifc.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_b2b", {31'b0, ifc.out_valid}, 32'd1);
      @(posedge clk); #1;
      ifc.in_valid = 1'b0;
    end

    // Random traffic with random backpressure; the request is held until accepted.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hs = ifc.in_valid && ifc.in_ready;
      @(posedge clk); #1;
      if (hs || !ifc.in_valid) begin
        if ($urandom_range(0, 9) < 8) rand_req();
        else ifc.in_valid = 1'b0;
      end
      ifc.out_ready = ($urandom_range(0, 3) != 0);
    end
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("drain_empty", q.size(), 32'd0);

    // Reset with both stages occupied.
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    send(32'h00000013, 32'h00000001, 3'b110);
    send(32'h00000013, 32'h00000002, 3'b000);
    @(negedge clk);
    check("mid_full_valid", {31'b0, ifc.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, ifc.out_valid}, 32'd0);
    check("mid_rst_count", {{(32-CW){1'b0}}, ifc.err_count}, 32'd0);
    check("mid_rst_in_ready", {31'b0, ifc.in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    ifc.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_valid", {31'b0, ifc.out_valid}, 32'd0);
    single("post_csr", 32'h00000073, 32'h0000001F, 3'b101, 32'h000F8073, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
